// File: rtl/cond_pkg.sv
// cond_pkg: shared definitions for the conditional-execution logic.
//   cond_e   : ARM condition field encodings EQ..AL plus NV (4'hF)
//   FLAG_*   : bit positions of N, Z, C, V inside the 4-bit flags word
//   FLAGS_W  : width of the flags word
package cond_pkg;

  localparam int FLAGS_W = 4;
  localparam int FLAG_N  = 3;
  localparam int FLAG_Z  = 2;
  localparam int FLAG_C  = 1;
  localparam int FLAG_V  = 0;

  typedef enum logic [3:0] {
    EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
    MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
    HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
    GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
  } cond_e;

endpackage

// File: rtl/cond_check.sv
// cond_check: purely combinational condition evaluator.
// Ports:
//   Cond   (in, 4)        instruction condition field
//   Flags  (in, FLAGS_W)  registered {N,Z,C,V}
//   CondEx (out, 1)       condition passes
// NV (4'hF) is treated as always-pass so the output is never X.
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0]         Cond,
  input  logic [FLAGS_W-1:0] Flags,
  output logic               CondEx
);

  logic n_s, z_s, c_s, v_s;

  assign n_s = Flags[FLAG_N];
  assign z_s = Flags[FLAG_Z];
  assign c_s = Flags[FLAG_C];
  assign v_s = Flags[FLAG_V];

  // Decode the condition field against the stored flags.
  always_comb begin
    CondEx = 1'b0;
    case (cond_e'(Cond))
      EQ:      CondEx = z_s;
      NE:      CondEx = ~z_s;
      CS:      CondEx = c_s;
      CC:      CondEx = ~c_s;
      MI:      CondEx = n_s;
      PL:      CondEx = ~n_s;
      VS:      CondEx = v_s;
      VC:      CondEx = ~v_s;
      HI:      CondEx = c_s & ~z_s;
      LS:      CondEx = ~c_s | z_s;
      GE:      CondEx = (n_s == v_s);
      LT:      CondEx = (n_s != v_s);
      GT:      CondEx = ~z_s & (n_s == v_s);
      LE:      CondEx = z_s | (n_s != v_s);
      AL:      CondEx = 1'b1;
      NV:      CondEx = 1'b1;
      default: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_logic.sv
// cond_logic: condition-gated write enables and the NZCV flags register.
// Ports:
//   clk, reset_n                 clock / asynchronous active-low reset
//   instr_valid                  instruction is real (not a bubble)
//   Cond[3:0]                    condition field
//   ALUFlags[3:0]                {N,Z,C,V} from the ALU this cycle
//   FlagW[1:0]                   [1] update N,Z ; [0] update C,V
//   PCS, RegW, MemW              unconditioned write requests
//   PCSrc, RegWrite, MemWrite    gated write enables (combinational)
//   CondEx                       condition passes (from registered Flags)
//   Flags[3:0]                   registered {N,Z,C,V}
//   exec_count, skip_count[31:0] executed / skipped instruction counters,
//                                present only when COND_STATS_EN is defined
module cond_logic
  import cond_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               instr_valid,
  input  logic [3:0]         Cond,
  input  logic [FLAGS_W-1:0] ALUFlags,
  input  logic [1:0]         FlagW,
  input  logic               PCS,
  input  logic               RegW,
  input  logic               MemW,
  output logic               PCSrc,
  output logic               RegWrite,
  output logic               MemWrite,
  output logic               CondEx,
  output logic [FLAGS_W-1:0] Flags
`ifdef COND_STATS_EN
  ,
  output logic [31:0]        exec_count,
  output logic [31:0]        skip_count
`endif
);

  logic [FLAGS_W-1:0] flags_r;
  logic [FLAGS_W-1:0] flags_nxt_s;
  logic               cond_ex_s;
  logic               exec_s;

  cond_check u_cond_check (
    .Cond   (Cond),
    .Flags  (flags_r),
    .CondEx (cond_ex_s)
  );

  // A real instruction whose condition passes.
  assign exec_s   = cond_ex_s & instr_valid;

  assign CondEx   = cond_ex_s;
  assign PCSrc    = PCS  & exec_s;
  assign RegWrite = RegW & exec_s;
  assign MemWrite = MemW & exec_s;
  assign Flags    = flags_r;

  // Next flags: each half loads independently from the ALU when enabled.
  always_comb begin
    flags_nxt_s = flags_r;
    if (exec_s && FlagW[1]) begin
      flags_nxt_s[FLAG_N] = ALUFlags[FLAG_N];
      flags_nxt_s[FLAG_Z] = ALUFlags[FLAG_Z];
    end else begin
      flags_nxt_s[FLAG_N] = flags_r[FLAG_N];
      flags_nxt_s[FLAG_Z] = flags_r[FLAG_Z];
    end
    if (exec_s && FlagW[0]) begin
      flags_nxt_s[FLAG_C] = ALUFlags[FLAG_C];
      flags_nxt_s[FLAG_V] = ALUFlags[FLAG_V];
    end else begin
      flags_nxt_s[FLAG_C] = flags_r[FLAG_C];
      flags_nxt_s[FLAG_V] = flags_r[FLAG_V];
    end
  end

  // Flags register; reset discards any write pending at the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_r <= {FLAGS_W{1'b0}};
    end else begin
      flags_r <= flags_nxt_s;
    end
  end

`ifdef COND_STATS_EN
  logic [31:0] exec_cnt_r;
  logic [31:0] skip_cnt_r;

  // Executed / skipped counters; bubbles count as neither. Wrap naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exec_cnt_r <= 32'd0;
      skip_cnt_r <= 32'd0;
    end else if (instr_valid) begin
      if (cond_ex_s) begin
        exec_cnt_r <= exec_cnt_r + 32'd1;
      end else begin
        skip_cnt_r <= skip_cnt_r + 32'd1;
      end
    end
  end

  assign exec_count = exec_cnt_r;
  assign skip_count = skip_cnt_r;
`endif

endmodule

// File: doc/cond_logic.md
COND_LOGIC -- requirements
Module: cond_logic

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for the flags register and counters.
REQ-002 SHALL have port: reset_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have port: instr_valid  input  1  current instruction is real (not a bubble).
REQ-004 SHALL have port: Cond  input  4  instruction condition field [31:28].
REQ-005 SHALL have port: ALUFlags  input  4  {N,Z,C,V} from the ALU, same cycle.
REQ-006 SHALL have port: FlagW  input  2  [1] = update N,Z; [0] = update C,V.
REQ-007 SHALL have port: PCS, RegW, MemW  input  1 each  decoder's unconditioned write requests.
REQ-008 SHALL have port: PCSrc, RegWrite, MemWrite  output  1 each  condition-gated write enables.
REQ-009 SHALL have port: CondEx  output  1  current instruction's condition passes.
REQ-010 SHALL have port: Flags  output  4  registered {N,Z,C,V}.
REQ-011 SHALL have ports (COND_STATS_EN only): exec_count, skip_count  output  32 each.

Function
REQ-012 SHALL evaluate CondEx combinationally from Cond and registered Flags only, never ALUFlags.
REQ-013 SHALL decode Cond: 0 EQ Z; 1 NE ~Z; 2 CS C; 3 CC ~C; 4 MI N; 5 PL ~N; 6 VS V; 7 VC ~V; 8 HI C&~Z; 9 LS ~C|Z; A GE N==V; B LT N!=V; C GT ~Z&(N==V); D LE Z|(N!=V); E AL 1; F 1.
REQ-014 SHALL drive PCSrc=PCS&CondEx&instr_valid, RegWrite=RegW&CondEx&instr_valid, MemWrite=MemW&CondEx&instr_valid, zero added latency.
REQ-015 SHALL load Flags[3:2] from ALUFlags[3:2] at posedge when FlagW[1]&CondEx&instr_valid; else hold.
REQ-016 SHALL load Flags[1:0] from ALUFlags[1:0] at posedge when FlagW[0]&CondEx&instr_valid; else hold.
REQ-017 SHALL allow both halves to update in the same cycle; new Flags visible the cycle after the write.
REQ-018 SHALL keep all outputs free of X for any Cond value, including 4'hF.

Reset
REQ-019 SHALL, on reset_n low, immediately clear Flags to 4'b0000 and counters to 0, independent of clk.
REQ-020 SHALL, after reset, evaluate EQ as fail, NE/AL as pass; reset asserted mid-instruction discards any pending flag write.

Configuration
REQ-021 SHALL, with COND_STATS_EN defined, increment exec_count when instr_valid&CondEx and skip_count when instr_valid&~CondEx, each wrapping 32'hFFFFFFFF->0.
REQ-022 SHALL, without COND_STATS_EN, omit exec_count/skip_count ports and counter logic entirely; all other behaviour identical.

Structure
REQ-023 SHALL place cond_e enum (EQ..AL,NV), flag bit indices (N=3,Z=2,C=1,V=0) and FLAGS_W=4 in shared package cond_pkg.
REQ-024 SHALL implement condition evaluation in one combinational sub-module cond_check (Cond, Flags -> CondEx).

Verification
REQ-025 SHALL check: reset, Cond=0 (EQ), RegW=1, valid=1 -> CondEx=0, RegWrite=0; Cond=E -> RegWrite=1.
REQ-026 SHALL check: AL, FlagW=11, ALUFlags=0110 -> next cycle Flags=0110; then Cond=0 -> CondEx=1, Cond=8 (HI) -> CondEx=0.
REQ-027 SHALL check: Flags=0000, Cond=0 (fails), FlagW=11, ALUFlags=1111 -> Flags stays 0000, MemWrite=0.
REQ-028 SHALL check: Flags=1111, FlagW=10, ALUFlags=0000, AL -> Flags=0011; then FlagW=01, ALUFlags=0000 -> Flags=0000.
REQ-029 SHALL check: instr_valid=0, AL, PCS=1, FlagW=11 -> PCSrc=0, Flags unchanged; reset_n pulsed low between clocks -> Flags=0 immediately.
REQ-030 SHALL check (COND_STATS_EN): 3 valid passing + 2 valid failing + 1 bubble -> exec_count=3, skip_count=2; preload count 32'hFFFFFFFF -> one pass wraps to 0.
